// File: rtl/gray_to_bin_seq.sv
// Bit-serial Gray-to-binary decoder: accepts a Gray word and decodes it MSB-first.
// It resolves one bit per clock, then holds the binary result until the consumer takes it.
module gray_to_bin_seq #(
   parameter int N  = 8,
   parameter int CW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_grey,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_bin,
   output logic         out_parity,
   output logic         busy
);

   // state | meaning
   // IDLE  | waiting for a Gray word, in_ready high
   // CALC  | resolving bin[idx] from the latched word, busy high
   // DONE  | result held on out_bin/out_parity, out_valid high
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [N-1:0]   g_reg;
   logic [N-1:0]   bin_reg;
   logic [CW-1:0]  idx;
   logic           par;
   logic           par_nxt;

   // The running XOR of g[N-1..i] is bin[i]; after the last bit it is also the word parity.
   assign par_nxt = par ^ g_reg[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         g_reg     <= '0;
         bin_reg   <= '0;
         idx       <= '0;
         par       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  g_reg    <= in_grey;
                  bin_reg  <= '0;
                  idx      <= CW'(N - 1);
                  par      <= 1'b0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CALC: begin
               bin_reg[idx] <= par_nxt;
               par          <= par_nxt;
               if (idx == '0) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx - CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_bin    = bin_reg;
   assign out_parity = par;

endmodule

// File: doc/gray_to_bin_seq.md
Name: gray_to_bin_seq

Overview:
Sequential Gray-to-binary decoder, the inverse of the team's binary-to-Gray encoder.
- Accepts an N-bit Gray word over a valid/ready handshake.
- Decodes it MSB-first, one bit per clock, then holds the binary result on a valid/ready output port until consumed.
- Sits on the receive side of Gray-coded paths, e.g. FIFO pointers and position counters, where area matters more than throughput.

Parameters:
N, 8, word width in bits; legal range 2..32.
CW, $clog2(N), width of the internal bit-index counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_grey holds a word to decode.
in_ready  output  1  block can accept a word (high only in IDLE).
in_grey  input  N  Gray-coded input word.
out_valid  output  1  out_bin holds a completed result.
out_ready  input  1  downstream accepts the result.
out_bin  output  N  decoded binary word.
out_parity  output  1  XOR-reduction of the accepted Gray word; must equal out_bin[0].
busy  output  1  high in CALC state.

Behaviour:
- Reset: rst sampled high at a rising edge forces all of the following, regardless of current state; any in-flight word is discarded and not reported:
  - state=IDLE
  - out_valid=0, out_bin=0, out_parity=0, busy=0
  - internal Gray register and index counter = 0
  - in_ready=1 from the first edge after rst deasserts
- States: IDLE, CALC, DONE; one-hot or binary encoding is implementer's choice.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_grey into the internal Gray register, clear the result register, set the index to N-1, clear the parity accumulator, go to CALC.
  - in_valid=0: stay in IDLE.
- CALC:
  - in_ready=0, busy=1; one result bit per edge at index i, starting at i=N-1.
  - i=N-1: bin[N-1] = g[N-1].
  - i<N-1: bin[i] = bin[i+1] ^ g[i].
  - parity accumulator ^= g[i].
  - Index decrements each edge. The edge that computes i=0 moves to DONE.
  - in_valid and in_grey are ignored in CALC; the latched copy is used, so in_grey may change freely after acceptance.
- DONE:
  - out_valid=1; out_bin and out_parity are stable and held unchanged while out_ready=0, for any number of cycles.
  - Edge with out_ready=1: go to IDLE, out_valid=0. out_bin keeps its last value and is don't-care while out_valid=0.
- Latency: the word is accepted at edge k; out_valid rises at edge k+N. Minimum spacing between accepted words is N+2 cycles, since in_ready is not asserted in DONE.
- No combinational path from in_valid or out_ready to in_ready or out_valid; all outputs come from registers or state decode.
- Width rules:
  - The index counter must cover 0..N-1 without wrap ambiguity; the CALC→DONE transition is decoded from index==0, not from an underflow.
  - N=2 is the smallest case: 2 CALC cycles.
- Simultaneous events:
  - rst together with in_valid: rst wins, nothing is accepted.
  - rst together with out_ready in DONE: rst wins; the result is lost and no further out_valid is raised for it.
- out_valid must never be asserted without a preceding acceptance since the last reset.

Test Plan:
- N=8, rst held 3 cycles, then idle: in_ready=1, out_valid=0, out_bin=0x00, busy=0 throughout.
- N=8, in_grey=0xCA accepted at edge k, out_ready=1: busy high for edges k..k+7, out_valid rises at edge k+8 with out_bin=0x8C, out_parity=0; in_ready returns high one cycle later.
- N=8, in_grey=0x80, then in_grey=0x01 accepted back-to-back at the earliest in_ready: out_bin=0xFF with out_parity=1, then out_bin=0x01 with out_parity=1; accept edges are 10 cycles apart.
- N=8, in_grey=0x00 accepted, out_ready held low 5 cycles after out_valid: out_bin=0x00 stable for all 5 cycles, in_ready=0 until one cycle after out_ready=1.
- N=8, rst asserted 3 edges into CALC for in_grey=0xCA: next cycle state=IDLE, in_ready=1, out_valid never rises for that word; a following word 0x01 decodes to 0x01.
- N=5, all 32 binary values run through the team's encoder into this block with random out_ready stalls: out_bin equals the encoder input every time, out_parity==out_bin[0], and in_grey changes during CALC have no effect.
